cache_req_arbiter: RTL
======================

# cache_req_arbiter

Two-port round-robin arbiter that shares the single CPU-side request port of `cache_controller` between an instruction-fetch requester (port 0) and a load/store requester (port 1). It latches one request at a time and issues it to the cache controller as a one-cycle `cpu_req_enable` pulse. It then waits for `cpu_res_ready` and returns the response, plus a completion pulse, to the granted requester only. It sits directly between the core's two memory ports and `cache_controller`.

## Interface
Parameters:
- `WORD_SIZE`, 32, address and data width.
- `TIMEOUT_CYCLES`, 256, watchdog limit in WAIT. Only used with `CACHE_ARB_TIMEOUT_EN`. Must be ≥2.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0_enable` / `req1_enable` in 1: request pending. Held high, with its payload stable, until that port's `ready` pulse.
- `req0_rw` / `req1_rw` in 1: 1 = write, 0 = read.
- `req0_addr` / `req1_addr` in WORD_SIZE: byte address.
- `req0_datain` / `req1_datain` in WORD_SIZE: write data.
- `req0_ready` / `req1_ready` out 1: one-cycle completion pulse.
- `req0_dataout` / `req1_dataout` out WORD_SIZE: read data. Valid from the `ready` cycle; held until the next read completion on that port.
- `req0_error` / `req1_error` out 1: timeout flag. Valid only while the same port's `ready` is high.
- `cpu_req_enable` out 1: one-cycle request pulse to the cache controller.
- `cpu_req_rw` out 1: latched rw to the cache controller.
- `cpu_req_addr` out WORD_SIZE: latched address to the cache controller.
- `cpu_req_datain` out WORD_SIZE: latched write data to the cache controller.
- `cpu_res_ready` in 1: completion from the cache controller.
- `cpu_res_dataout` in WORD_SIZE: read data from the cache controller.
- `arb_grant` out 2: one-hot owner. Nonzero from ISSUE through RESPOND, 0 in IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND. All outputs are registered.
- IDLE: if any `reqN_enable` is high, select the winner, latch its rw/addr/datain into the `cpu_req_*` registers, set `arb_grant`, and go to ISSUE. Otherwise stay.
- Arbitration: round-robin on a 1-bit `last` pointer.
  - Both requesting: grant the port ≠ `last`.
  - One requesting: grant it.
  - `last` updates to the granted port on entry to RESPOND.
- ISSUE: `cpu_req_enable` = 1 for exactly this cycle. Go to WAIT.
- WAIT: on `cpu_res_ready` = 1, go to RESPOND.
  - On a read, capture `cpu_res_dataout` into the granted port's `dataout`.
  - On a write, `dataout` is unchanged.
  - `cpu_res_ready` seen in ISSUE is ignored.
- RESPOND: the granted port's `ready` = 1 for one cycle, `error` = 0. Go to IDLE.
- Requester contract: drop `enable` at the edge that ends its `ready` cycle. The arbiter samples it again in IDLE, one edge later.
- `cpu_res_ready` in IDLE or RESPOND is ignored.
- Latched `cpu_req_addr`, `cpu_req_rw` and `cpu_req_datain` hold until the next grant, even if the requester's inputs change.

## Timing
- Reset values:
  - state IDLE; `last` = 1, so port 0 wins the first tie.
  - All `ready`, `error`, `dataout`, `cpu_req_*` and `arb_grant` = 0.
  - Watchdog counter = 0.
- Reset asserted mid-operation: all outputs clear immediately (asynchronous). No `ready` pulse is issued for the abandoned request.
- Latency, enable sampled at edge k:
  - `cpu_req_enable` high in cycle k+1.
  - `cpu_res_ready` first seen at edge m (m ≥ k+2) → `reqN_ready` high in cycle m+1.
  - Minimum enable-to-ready: 3 cycles.
- Throughput: the next grant is sampled in IDLE, the edge after RESPOND. Back-to-back requests start 4 cycles apart at best.
- Simultaneous new requests in RESPOND are not arbitrated until IDLE.

## Configuration
- `CACHE_ARB_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the count reaches `TIMEOUT_CYCLES` without `cpu_res_ready`: go to RESPOND with `error` = 1 and `dataout` forced to 0.
  - A `cpu_res_ready` arriving in the same cycle as the limit wins: normal completion, `error` = 0.
- `CACHE_ARB_TIMEOUT_EN` undefined:
  - No counter; WAIT persists indefinitely.
  - `req0_error` and `req1_error` are tied to 0.

## Test plan
- Port 0 read of 0x00000000; model returns `cpu_res_ready` with 0xDEADBEEF two cycles after the pulse:
  - exactly one `cpu_req_enable` pulse with addr 0x00000000 and rw = 0;
  - `req0_ready` pulses once with `req0_dataout` = 0xDEADBEEF;
  - `req1_ready` stays 0.
- Both ports enabled in the same cycle after reset (port 0 read 0x10, port 1 write 0x12345678 to 0x20):
  - port 0 is served first;
  - port 1 issues next with `cpu_req_datain` = 0x12345678 and rw = 1;
  - `arb_grant` sequence is 01 then 10.
- Both ports requesting continuously for 6 transactions → grants alternate 0,1,0,1,0,1.
- Port 1 write completes → `req1_ready` pulses; `req1_dataout` keeps its previous read value (0xCAFEFACE).
- Assert `rst` in WAIT:
  - `cpu_req_*`, `arb_grant` and `ready` go to 0 without waiting for a clock edge;
  - after release, a new port 1 request is served normally.
- With `CACHE_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, and `cpu_res_ready` never asserted → `req0_ready` = 1 with `req0_error` = 1 and `req0_dataout` = 0 on the cycle after the 8th WAIT cycle; the FSM returns to IDLE.

Source files
------------

// File: rtl/cache_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter_if
//
// Bundles every handshake/bus signal around cache_req_arbiter: the two
// requester ports (instruction fetch = port 0, load/store = port 1), the
// CPU-side request/response port of cache_controller and the grant vector.
//
// Modports:
//   slave  - the arbiter's view (requests and cache response in,
//            completions and cache request out)
//   master - the environment's view (requesters plus cache controller)
//
// Signals (WORD_SIZE = address/data width):
//   reqN_enable/rw/addr/datain    requester N -> arbiter
//   reqN_ready/dataout/error      arbiter -> requester N
//   cpu_req_enable/rw/addr/datain arbiter -> cache controller
//   cpu_res_ready/dataout         cache controller -> arbiter
//   arb_grant                     arbiter -> observers (one-hot owner)
// ---------------------------------------------------------------------------
interface cache_req_arbiter_if #(
    parameter int WORD_SIZE = 32
);
    logic                 req0_enable;
    logic                 req0_rw;
    logic [WORD_SIZE-1:0] req0_addr;
    logic [WORD_SIZE-1:0] req0_datain;
    logic                 req0_ready;
    logic [WORD_SIZE-1:0] req0_dataout;
    logic                 req0_error;

    logic                 req1_enable;
    logic                 req1_rw;
    logic [WORD_SIZE-1:0] req1_addr;
    logic [WORD_SIZE-1:0] req1_datain;
    logic                 req1_ready;
    logic [WORD_SIZE-1:0] req1_dataout;
    logic                 req1_error;

    logic                 cpu_req_enable;
    logic                 cpu_req_rw;
    logic [WORD_SIZE-1:0] cpu_req_addr;
    logic [WORD_SIZE-1:0] cpu_req_datain;
    logic                 cpu_res_ready;
    logic [WORD_SIZE-1:0] cpu_res_dataout;

    logic [1:0]           arb_grant;

    modport slave (
        input  req0_enable, req0_rw, req0_addr, req0_datain,
        output req0_ready, req0_dataout, req0_error,
        input  req1_enable, req1_rw, req1_addr, req1_datain,
        output req1_ready, req1_dataout, req1_error,
        output cpu_req_enable, cpu_req_rw, cpu_req_addr, cpu_req_datain,
        input  cpu_res_ready, cpu_res_dataout,
        output arb_grant
    );

    modport master (
        output req0_enable, req0_rw, req0_addr, req0_datain,
        input  req0_ready, req0_dataout, req0_error,
        output req1_enable, req1_rw, req1_addr, req1_datain,
        input  req1_ready, req1_dataout, req1_error,
        input  cpu_req_enable, cpu_req_rw, cpu_req_addr, cpu_req_datain,
        output cpu_res_ready, cpu_res_dataout,
        input  arb_grant
    );
endinterface

// File: rtl/cache_req_arbiter.sv
// ---------------------------------------------------------------------------
// cache_req_arbiter
//
// Shares the single CPU-side request port of cache_controller between an
// instruction-fetch requester (port 0) and a load/store requester (port 1).
// One request is latched at a time, issued as a one-cycle cpu_req_enable
// pulse, and its completion (ready pulse + read data) is routed back to the
// granted port only. Arbitration is round-robin on a 1-bit 'last' pointer;
// port 0 wins the first tie after reset.
//
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - cache_req_arbiter_if.slave (requesters, cache port, arb_grant)
//
// Optional feature macro: CACHE_ARB_TIMEOUT_EN
//   Defined   - WAIT watchdog; after TIMEOUT_CYCLES WAIT cycles without
//               cpu_res_ready the request completes with error = 1 and
//               dataout = 0.
//   Undefined - no watchdog, WAIT persists, error outputs tied to 0.
// ---------------------------------------------------------------------------
module cache_req_arbiter #(
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input logic                clk,
    input logic                rst,
    cache_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESPOND
    } state_t;

    state_t                        state_reg;
    logic                          last_reg;      // port granted most recently
    logic                          gnt_idx_reg;   // port owning the current request
    logic [1:0]                    grant_reg;
    logic                          cpu_req_enable_reg;
    logic                          cpu_req_rw_reg;
    logic [WORD_SIZE-1:0]          cpu_req_addr_reg;
    logic [WORD_SIZE-1:0]          cpu_req_datain_reg;
    logic [1:0]                    ready_reg;
    logic [1:0][WORD_SIZE-1:0]     dataout_reg;

    // Requester inputs gathered into port-indexed vectors.
    logic [1:0]                    req_enable;
    logic [1:0]                    req_rw;
    logic [1:0][WORD_SIZE-1:0]     req_addr;
    logic [1:0][WORD_SIZE-1:0]     req_datain;
    logic                          win_next;

    assign req_enable = {bus.req1_enable, bus.req0_enable};
    assign req_rw     = {bus.req1_rw, bus.req0_rw};
    assign req_addr   = {bus.req1_addr, bus.req0_addr};
    assign req_datain = {bus.req1_datain, bus.req0_datain};

    // Both requesting: the port that did not go last. Otherwise the single
    // requester (req_enable[1] is 0 exactly when only port 0 asks).
    always_comb begin
        win_next = req_enable[1];
        if (&req_enable) begin
            win_next = ~last_reg;
        end
    end

    // A watchdog limit below 2 is not a supported configuration; the empty
    // block keeps the parameter referenced in every build.
    if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_unsupported
    end

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;

    logic [CNT_W-1:0] wdog_cnt_reg;
    logic [1:0]       error_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            last_reg           <= 1'b1;
            gnt_idx_reg        <= 1'b0;
            grant_reg          <= 2'b00;
            cpu_req_enable_reg <= 1'b0;
            cpu_req_rw_reg     <= 1'b0;
            cpu_req_addr_reg   <= '0;
            cpu_req_datain_reg <= '0;
            ready_reg          <= 2'b00;
            dataout_reg        <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            wdog_cnt_reg       <= '0;
            error_reg          <= 2'b00;
`endif
        end else begin
            // Pulse outputs default low; each is raised for one state only.
            cpu_req_enable_reg <= 1'b0;
            ready_reg          <= 2'b00;
`ifdef CACHE_ARB_TIMEOUT_EN
            error_reg          <= 2'b00;
`endif
            case (state_reg)
                ST_IDLE: begin
                    if (|req_enable) begin
                        gnt_idx_reg        <= win_next;
                        grant_reg          <= win_next ? 2'b10 : 2'b01;
                        cpu_req_rw_reg     <= req_rw[win_next];
                        cpu_req_addr_reg   <= req_addr[win_next];
                        cpu_req_datain_reg <= req_datain[win_next];
                        cpu_req_enable_reg <= 1'b1;
                        state_reg          <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    // cpu_res_ready during the issue cycle is not a response
                    // to this request and is deliberately ignored.
`ifdef CACHE_ARB_TIMEOUT_EN
                    wdog_cnt_reg <= '0;
`endif
                    state_reg <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (bus.cpu_res_ready) begin
                        if (!cpu_req_rw_reg) begin
                            dataout_reg[gnt_idx_reg] <= bus.cpu_res_dataout;
                        end
                        ready_reg[gnt_idx_reg] <= 1'b1;
                        last_reg               <= gnt_idx_reg;
                        state_reg              <= ST_RESPOND;
                    end
`ifdef CACHE_ARB_TIMEOUT_EN
                    // Counter holds the number of completed WAIT cycles minus
                    // one, so the limit is hit at the end of the last cycle.
                    else if (wdog_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        dataout_reg[gnt_idx_reg] <= '0;
                        error_reg[gnt_idx_reg]   <= 1'b1;
                        ready_reg[gnt_idx_reg]   <= 1'b1;
                        last_reg                 <= gnt_idx_reg;
                        state_reg                <= ST_RESPOND;
                    end else begin
                        wdog_cnt_reg <= wdog_cnt_reg + CNT_W'(1);
                    end
`endif
                end

                ST_RESPOND: begin
                    grant_reg <= 2'b00;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    grant_reg <= 2'b00;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cpu_req_enable = cpu_req_enable_reg;
    assign bus.cpu_req_rw     = cpu_req_rw_reg;
    assign bus.cpu_req_addr   = cpu_req_addr_reg;
    assign bus.cpu_req_datain = cpu_req_datain_reg;
    assign bus.arb_grant      = grant_reg;

    assign bus.req0_ready     = ready_reg[0];
    assign bus.req1_ready     = ready_reg[1];
    assign bus.req0_dataout   = dataout_reg[0];
    assign bus.req1_dataout   = dataout_reg[1];

`ifdef CACHE_ARB_TIMEOUT_EN
    assign bus.req0_error     = error_reg[0];
    assign bus.req1_error     = error_reg[1];
`else
    assign bus.req0_error     = 1'b0;
    assign bus.req1_error     = 1'b0;
`endif

endmodule
